output_drain: RTL and testbench
===============================

// Module: output_drain
// PURPOSE
//  Drains the convolution output buffer after a layer pass completes. On start, scans
//  output_vals in channel-major order (ch, row, col), PACK elements per beat, applies
//  optional ReLU, saturates each element to OUT_DATA_W, and streams beats to the
//  writeback interface over a valid/ready handshake. Sits directly downstream of the
//  output buffer. Asserts buf_lock so upstream holds off writes while draining.
// PARAMETERS
//  OUT_CH      16  output channels in the buffer
//  OUT_H       8   output rows
//  OUT_W       8   output columns; must be a multiple of PACK
//  DATA_W      32  signed width of each buffer element
//  OUT_DATA_W  16  signed width of each streamed element; OUT_DATA_W <= DATA_W
//  PACK        4   elements per output beat
// PORTS
//  clock      in   1                        rising-edge clock
//  reset      in   1                        asynchronous, active-high; clears all state
//  start      in   1                        one-cycle pulse; begins a drain (IDLE only)
//  relu_en    in   1                        sampled at accepted start; 1 = clamp negatives to 0
//  buf_vals   in   DATA_W x OUT_CH x OUT_H x OUT_W  output buffer contents; stable while buf_lock=1
//  buf_lock   out  1                        1 from cycle after start until done; upstream must not write
//  m_valid    out  1                        beat valid
//  m_ready    in   1                        sink accepts beat when m_valid && m_ready
//  m_data     out  PACK*OUT_DATA_W          element k at bits [k*OUT_DATA_W +: OUT_DATA_W], k=0 lowest col
//  m_ch_last  out  1                        beat is last of current channel
//  m_last     out  1                        beat is last of whole tensor
//  done       out  1                        one-cycle pulse after final beat accepted
// BEHAVIOUR
//  Reset values: buf_lock=0, m_valid=0, m_data=0, m_ch_last=0, m_last=0, done=0, FSM=IDLE, counters=0.
//  Reset mid-drain: outputs go to reset values immediately (async). No beat is resumed.
//  FSM states: IDLE, STREAM, DONE.
//   IDLE  : start=1 -> latch relu_en, ch=row=colgrp=0, go STREAM. start in other states ignored.
//   STREAM: m_valid=1; beat = buf_vals[ch][row][colgrp*PACK +: PACK] after ReLU/saturation.
//           On handshake: advance colgrp, then row, then ch. Final beat accepted -> DONE.
//           No handshake: m_data/m_ch_last/m_last held stable. m_valid never drops without a handshake.
//   DONE  : done=1 for one cycle, buf_lock=0, m_valid=0 -> IDLE.
//  Timing: start at edge t -> m_valid=1, beat 0 at t+1. With m_ready held 1, one beat/cycle.
//   Total beats N = OUT_CH*OUT_H*OUT_W/PACK. Final handshake at edge t+N -> done=1 in cycle t+N+1.
//  buf_lock=1 in STREAM only. start coincident with DONE is ignored.
//  Element transform, per element x (signed DATA_W):
//   relu on and x<0 -> 0.
//   Saturate to [-2^(OUT_DATA_W-1), 2^(OUT_DATA_W-1)-1]; in-range values are truncated losslessly.
//  Flags: m_ch_last=1 when row=OUT_H-1 and colgrp=OUT_W/PACK-1. m_last=m_ch_last and ch=OUT_CH-1.
//  Registered output: m_data comes from a register loaded on entry to STREAM and on each handshake.
//   No combinational path from m_ready to m_data.
// TESTING
//  1 Reset then start, m_ready=1, buf[c][r][x]=c*64+r*8+x
//    -> 32 beats (OUT_CH=1,H=8,W=8,PACK=2) in order;
//    -> beat0 data={1,0}; m_last only on beat 31; done 1 cycle later.
//  2 m_ready toggling 1,0,0,1 pattern
//    -> no beat lost or duplicated; m_data stable across stalls; beat count exact.
//  3 relu_en=1, elements -5, 7, 40000, -40000 (OUT_DATA_W=16)
//    -> 0, 7, 32767, 0. With relu_en=0 -> -5, 7, 32767, -32768.
//  4 Reset asserted mid-STREAM at beat 10
//    -> m_valid, buf_lock drop same cycle; next start restarts at beat 0.
//  5 start pulsed during STREAM and during the DONE cycle
//    -> ignored; exactly one drain, one done pulse.
//  6 Default params, m_ready=1
//    -> m_ch_last every 16 beats; buf_lock high exactly 256 cycles.

Source files
------------

// File: rtl/output_drain_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | output_drain_if : valid/ready beat stream from output_drain to writeback  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface output_drain_if #(
   parameter int PACK       = 4,
   parameter int OUT_DATA_W = 16
);
   logic                         valid;
   logic                         ready;
   logic [PACK*OUT_DATA_W-1:0]   data;
   logic                         ch_last;
   logic                         last;

   modport master (output valid, data, ch_last, last, input ready);
   modport slave  (input valid, data, ch_last, last, output ready);
endinterface
`default_nettype wire

// File: rtl/output_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | output_drain : streams the conv output buffer channel-major, with        |
// |                optional ReLU and saturation, PACK elements per beat.      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module output_drain #(
   parameter int OUT_CH     = 16,
   parameter int OUT_H      = 8,
   parameter int OUT_W      = 8,
   parameter int DATA_W     = 32,
   parameter int OUT_DATA_W = 16,
   parameter int PACK       = 4
) (
   input  wire logic                     clock,
   input  wire logic                     reset,
   input  wire logic                     start,
   input  wire logic                     relu_en,
   input  wire logic signed [DATA_W-1:0] buf_vals [OUT_CH][OUT_H][OUT_W],
   output logic                          buf_lock,
   output logic                          done,
   output_drain_if.master                m
);

   localparam int c_NGRP  = OUT_W / PACK;
   localparam int c_CH_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
   localparam int c_ROW_W = (OUT_H  > 1) ? $clog2(OUT_H)  : 1;
   localparam int c_COL_W = (OUT_W  > 1) ? $clog2(OUT_W)  : 1;
   localparam int c_GRP_W = (c_NGRP > 1) ? $clog2(c_NGRP) : 1;

   localparam logic [c_CH_W-1:0]  c_CH_LAST  = c_CH_W'(OUT_CH - 1);
   localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(OUT_H - 1);
   localparam logic [c_GRP_W-1:0] c_GRP_LAST = c_GRP_W'(c_NGRP - 1);

   // Saturation bounds expressed at the input width so the compare is exact.
   localparam logic signed [DATA_W-1:0] c_MAX =
      {{(DATA_W-OUT_DATA_W+1){1'b0}}, {(OUT_DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] c_MIN = ~c_MAX;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                     r_state;
   logic [c_CH_W-1:0]          r_ch;
   logic [c_ROW_W-1:0]         r_row;
   logic [c_GRP_W-1:0]         r_grp;
   logic                       r_relu;
   logic                       r_valid;
   logic                       r_lock;
   logic                       r_done;
   logic                       r_ch_last;
   logic                       r_last;
   logic [PACK*OUT_DATA_W-1:0] r_data;

   logic [c_CH_W-1:0]          w_ch;
   logic [c_ROW_W-1:0]         w_row;
   logic [c_GRP_W-1:0]         w_grp;
   logic                       w_relu;
   logic                       w_fire;
   logic                       w_ch_last_nxt;
   logic                       w_last_nxt;
   logic [c_COL_W-1:0]         w_col [PACK];
   logic [PACK*OUT_DATA_W-1:0] w_beat;

   function automatic logic [OUT_DATA_W-1:0] f_xform(
      input logic signed [DATA_W-1:0] x,
      input logic                     relu
   );
      logic signed [DATA_W-1:0] v;
      v = (relu && x[DATA_W-1]) ? '0 : x;
      if (v > c_MAX)
         return c_MAX[OUT_DATA_W-1:0];
      else if (v < c_MIN)
         return c_MIN[OUT_DATA_W-1:0];
      else
         return v[OUT_DATA_W-1:0];
   endfunction

   assign w_fire = r_valid && m.ready;
   assign w_relu = (r_state == S_IDLE) ? relu_en : r_relu;

   // Indices of the beat to load next: zero on entry, successor while streaming.
   always_comb begin
      w_ch  = '0;
      w_row = '0;
      w_grp = '0;
      if (r_state == S_STREAM) begin
         w_ch  = r_ch;
         w_row = r_row;
         w_grp = (r_grp == c_GRP_LAST) ? '0 : r_grp + c_GRP_W'(1);
         if (r_grp == c_GRP_LAST) begin
            w_row = (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_W'(1);
            if (r_row == c_ROW_LAST)
               w_ch = (r_ch == c_CH_LAST) ? '0 : r_ch + c_CH_W'(1);
         end
      end
   end

   assign w_ch_last_nxt = (w_row == c_ROW_LAST) && (w_grp == c_GRP_LAST);
   assign w_last_nxt    = w_ch_last_nxt && (w_ch == c_CH_LAST);

   generate
      for (genvar k = 0; k < PACK; k++) begin : g_lane
         assign w_col[k] = c_COL_W'(int'(w_grp) * PACK + k);
         assign w_beat[k*OUT_DATA_W +: OUT_DATA_W] =
            f_xform(buf_vals[w_ch][w_row][w_col[k]], w_relu);
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ch      <= '0;
         r_row     <= '0;
         r_grp     <= '0;
         r_relu    <= 1'b0;
         r_valid   <= 1'b0;
         r_lock    <= 1'b0;
         r_done    <= 1'b0;
         r_ch_last <= 1'b0;
         r_last    <= 1'b0;
         r_data    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state   <= S_STREAM;
                  r_relu    <= relu_en;
                  r_ch      <= w_ch;
                  r_row     <= w_row;
                  r_grp     <= w_grp;
                  r_valid   <= 1'b1;
                  r_lock    <= 1'b1;
                  r_data    <= w_beat;
                  r_ch_last <= w_ch_last_nxt;
                  r_last    <= w_last_nxt;
               end
            end
            S_STREAM: begin
               if (w_fire) begin
                  if (r_last) begin
                     r_state   <= S_DONE;
                     r_valid   <= 1'b0;
                     r_lock    <= 1'b0;
                     r_done    <= 1'b1;
                     r_ch_last <= 1'b0;
                     r_last    <= 1'b0;
                  end else begin
                     r_ch      <= w_ch;
                     r_row     <= w_row;
                     r_grp     <= w_grp;
                     r_data    <= w_beat;
                     r_ch_last <= w_ch_last_nxt;
                     r_last    <= w_last_nxt;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_lock  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign buf_lock  = r_lock;
   assign done      = r_done;
   assign m.valid   = r_valid;
   assign m.data    = r_data;
   assign m.ch_last = r_ch_last;
   assign m.last    = r_last;

endmodule
`default_nettype wire

// File: tb/tb_output_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_output_drain : directed checks on a 1x8x8/PACK=2 drain and a default   |
// |                   16x8x8/PACK=4 drain.                                    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_output_drain;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic s_start = 1'b0, s_relu = 1'b0, s_lock, s_done;
   logic d_start = 1'b0, d_relu = 1'b0, d_lock, d_done;
   logic signed [31:0] sbuf [1][8][8];
   logic signed [31:0] dbuf [16][8][8];
   int checks = 0;
   int failures = 0;

   output_drain_if #(.PACK(2), .OUT_DATA_W(16)) s_if ();
   output_drain_if #(.PACK(4), .OUT_DATA_W(16)) d_if ();

   output_drain #(.OUT_CH(1), .OUT_H(8), .OUT_W(8), .DATA_W(32), .OUT_DATA_W(16), .PACK(2)) u_small (
      .clock(clock), .reset(reset), .start(s_start), .relu_en(s_relu),
      .buf_vals(sbuf), .buf_lock(s_lock), .done(s_done), .m(s_if.master));

   output_drain #(.OUT_CH(16), .OUT_H(8), .OUT_W(8), .DATA_W(32), .OUT_DATA_W(16), .PACK(4)) u_dflt (
      .clock(clock), .reset(reset), .start(d_start), .relu_en(d_relu),
      .buf_vals(dbuf), .buf_lock(d_lock), .done(d_done), .m(d_if.master));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] xf(input logic signed [31:0] x, input logic relu);
      logic signed [31:0] v;
      v = (relu && x < 0) ? 32'sd0 : x;
      if (v > 32767)  return 16'h7fff;
      if (v < -32768) return 16'h8000;
      return v[15:0];
   endfunction

   function automatic logic [31:0] exp_s(input int idx, input logic relu);
      int r = idx / 4;
      int g = idx % 4;
      return {xf(sbuf[0][r][2*g+1], relu), xf(sbuf[0][r][2*g], relu)};
   endfunction

   function automatic logic [63:0] exp_d(input int idx);
      int c = idx / 16;
      int r = (idx % 16) / 2;
      int g = idx % 2;
      return {xf(dbuf[c][r][4*g+3], 1'b0), xf(dbuf[c][r][4*g+2], 1'b0),
              xf(dbuf[c][r][4*g+1], 1'b0), xf(dbuf[c][r][4*g],   1'b0)};
   endfunction

   // mode 0: ready always 1; mode 1: ready repeats 1,0,0,1. poke pulses start mid-stream and in DONE.
   task automatic drain_small(input int mode, input logic relu, input bit poke,
                              output logic [31:0] b0, output logic [31:0] b1);
      int idx = 0;
      int cyc = 0;
      int dones = 0;
      logic rdy;
      b0 = '0;
      b1 = '0;
      @(negedge clock);
      s_start = 1'b1;
      s_relu  = relu;
      @(negedge clock);
      s_start = 1'b0;
      s_relu  = ~relu;
      chk("lock_after_start", s_lock, 1'b1);
      while (idx < 32 && cyc < 400) begin
         chk("valid_held", s_if.valid, 1'b1);
         chk("beat_data", s_if.data, exp_s(idx, relu));
         if (idx == 0) b0 = s_if.data;
         if (idx == 1) b1 = s_if.data;
         rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         s_if.ready = rdy;
         s_start = poke && (idx == 5);
         if (rdy) begin
            chk("m_last", s_if.last, idx == 31);
            chk("m_ch_last", s_if.ch_last, idx == 31);
            idx++;
         end
         cyc++;
         @(negedge clock);
         dones += int'(s_done);
      end
      chk("beat_count", idx, 32);
      if (mode == 0) chk("stream_cycles", cyc, 32);
      chk("done_pulse", s_done, 1'b1);
      chk("valid_after_last", s_if.valid, 1'b0);
      chk("lock_after_last", s_lock, 1'b0);
      s_if.ready = 1'b0;
      s_start = poke;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         s_start = 1'b0;
         dones += int'(s_done);
         chk("idle_valid", s_if.valid, 1'b0);
         chk("idle_lock", s_lock, 1'b0);
      end
      chk("done_pulses", dones, 1);
   endtask

   initial begin
      logic [31:0] b0, b1;
      int idx, lockcyc, dones;
      s_if.ready = 1'b0;
      d_if.ready = 1'b0;
      for (int c = 0; c < 16; c++)
         for (int r = 0; r < 8; r++)
            for (int x = 0; x < 8; x++) begin
               dbuf[c][r][x] = c*64 + r*8 + x;
               if (c == 0) sbuf[0][r][x] = r*8 + x;
            end

      // Reset state
      @(negedge clock);
      @(negedge clock);
      chk("rst_lock", s_lock, 1'b0);
      chk("rst_valid", s_if.valid, 1'b0);
      chk("rst_data", s_if.data, 32'h0);
      chk("rst_ch_last", s_if.ch_last, 1'b0);
      chk("rst_last", s_if.last, 1'b0);
      chk("rst_done", s_done, 1'b0);
      chk("rst_d_valid", d_if.valid, 1'b0);
      chk("rst_d_lock", d_lock, 1'b0);
      reset = 1'b0;

      // Ordered drain, one beat per cycle
      drain_small(0, 1'b0, 1'b0, b0, b1);
      chk("beat0_hand", b0, 32'h0001_0000);
      chk("beat1_hand", b1, 32'h0003_0002);

      // Stalled drain with 1,0,0,1 ready
      drain_small(1, 1'b0, 1'b0, b0, b1);
      chk("stall_beat0", b0, 32'h0001_0000);

      // ReLU and saturation
      sbuf[0][0][0] = -5;
      sbuf[0][0][1] = 7;
      sbuf[0][0][2] = 40000;
      sbuf[0][0][3] = -40000;
      drain_small(0, 1'b1, 1'b0, b0, b1);
      chk("relu_beat0", b0, 32'h0007_0000);
      chk("relu_beat1", b1, 32'h0000_7fff);
      drain_small(1, 1'b0, 1'b0, b0, b1);
      chk("sat_beat0", b0, 32'h0007_fffb);
      chk("sat_beat1", b1, 32'h8000_7fff);

      // Reset mid-stream at beat 10
      @(negedge clock);
      s_start = 1'b1;
      s_if.ready = 1'b1;
      @(negedge clock);
      s_start = 1'b0;
      for (int i = 0; i < 10; i++) @(negedge clock);
      chk("pre_rst_beat10", s_if.data, exp_s(10, 1'b0));
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", s_if.valid, 1'b0);
      chk("mid_rst_lock", s_lock, 1'b0);
      chk("mid_rst_data", s_if.data, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      s_if.ready = 1'b0;
      drain_small(0, 1'b0, 1'b0, b0, b1);
      chk("restart_beat0", b0, 32'h0007_fffb);

      // start pulsed during STREAM and DONE is ignored
      drain_small(0, 1'b0, 1'b1, b0, b1);

      // Default-parameter drain
      @(negedge clock);
      d_start = 1'b1;
      @(negedge clock);
      d_start = 1'b0;
      d_if.ready = 1'b1;
      idx = 0;
      lockcyc = 0;
      dones = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         lockcyc += int'(d_lock);
         dones += int'(d_done);
         if (d_if.valid) begin
            chk("d_data", d_if.data, exp_d(idx));
            chk("d_ch_last", d_if.ch_last, (idx % 16) == 15);
            chk("d_last", d_if.last, idx == 255);
            idx++;
         end
         @(negedge clock);
      end
      chk("d_beats", idx, 256);
      chk("d_lock_cycles", lockcyc, 256);
      chk("d_done_pulses", dones, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
